cdb_arbiter: RTL and testbench

//   Shares the single common data bus (CDB) between NUM_SRC functional units (ALUs etc.).

---
 rtl/cdb_arbiter_pkg.sv | 16 +
 rtl/cdb_arbiter.sv | 95 +++++++++
 tb/tb_cdb_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Common data bus payload shared by the functional units and the CDB arbiter.
package cdb_arbiter_pkg;

  localparam int unsigned TAG_W = 6;
  localparam int unsigned VAL_W = 32;

  // Tag value reserved to mean "no result present"
  localparam logic [TAG_W-1:0] NO_VAL = '0;
  localparam logic [TAG_W-1:0] ALU_1  = TAG_W'(1);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [VAL_W-1:0] val;
  } cdb_t;

endpackage

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: one FU result per cycle is
// accepted and broadcast from a register one cycle later.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  cdb_t [NUM_SRC-1:0] src_term_i,
  output logic [NUM_SRC-1:0] src_ready_o,
  input  logic               flush_i,
  output cdb_t               cdb_term_o,
  output logic [31:0]        bcast_cnt_o
);

  localparam int unsigned PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned LAST  = NUM_SRC - 1;

  logic [NUM_SRC-1:0] req;
  logic               found;
  logic [PTR_W-1:0]   found_idx;
  logic               grant;
  logic [PTR_W-1:0]   rr_ptr_q;
  logic [PTR_W-1:0]   rr_ptr_d;
  cdb_t               cdb_term_q;
  logic [CNT_W-1:0]   bcast_cnt_q;

  // A source requests whenever it presents a real tag
  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      req[i] = (src_term_i[i].tag != NO_VAL);
    end
  end

  // Scan from the round-robin pointer and take the first requester
  always_comb begin
    int unsigned idx;
    idx       = 0;
    found     = 1'b0;
    found_idx = '0;
    for (int unsigned off = 0; off < NUM_SRC; off++) begin
      idx = (32'(rr_ptr_q) + off) % NUM_SRC;
      if (!found && req[idx]) begin
        found     = 1'b1;
        found_idx = PTR_W'(idx);
      end
    end
  end

  // Flush and reset suppress the grant; losers simply keep holding their terms
  always_comb begin
    grant       = found && !flush_i && !reset_i;
    src_ready_o = '0;
    if (grant) begin
      src_ready_o[found_idx] = 1'b1;
    end
  end

  // Pointer moves just past the winner, wrapping at the last source
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      if (32'(found_idx) == LAST) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = found_idx + PTR_W'(1);
      end
    end
  end

  // Broadcast register, pointer and broadcast counter
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rr_ptr_q       <= '0;
      cdb_term_q.tag <= NO_VAL;
      cdb_term_q.val <= '0;
      bcast_cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (grant) begin
        cdb_term_q  <= src_term_i[found_idx];
        bcast_cnt_q <= bcast_cnt_q + CNT_W'(1);
      end else begin
        cdb_term_q.tag <= NO_VAL;
      end
    end
  end

  assign cdb_term_o  = cdb_term_q;
  assign bcast_cnt_o = bcast_cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a driver applies per-FU result queues and a
// round-robin reference model; a monitor checks every broadcast against the model.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int unsigned N = 4;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic         flush_i;
  cdb_t [N-1:0] src_term_i;
  logic [N-1:0] src_ready_o;
  cdb_t         cdb_term_o;
  logic [31:0]  bcast_cnt_o;

  cdb_arbiter #(.NUM_SRC(N)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .src_term_i  (src_term_i),
    .src_ready_o (src_ready_o),
    .flush_i     (flush_i),
    .cdb_term_o  (cdb_term_o),
    .bcast_cnt_o (bcast_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    cdb_t term;
    int   cyc;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  exp_t        exp_q[$];
  cdb_t        src_q[N][$];
  int          glog[$];
  int          m_ptr  = 0;
  int unsigned m_cnt  = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic cdb_t mk(input logic [TAG_W-1:0] tag, input logic [31:0] val);
    cdb_t t;
    t.tag = tag;
    t.val = val;
    return t;
  endfunction

  function automatic cdb_t rnd_term();
    return mk(TAG_W'($urandom_range(1, 63)), $urandom);
  endfunction

  // One cycle: present queue heads, predict the winner, check ready, score it
  task automatic step(input bit fl);
    int best;
    int bestd;
    int d;
    logic [N-1:0] exp_ready;
    @(negedge clk_i);
    flush_i = fl;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) src_term_i[i] = src_q[i][0];
      else src_term_i[i] = mk(NO_VAL, $urandom);
    end
    #1;
    best  = -1;
    bestd = N;
    if (!reset_i && !fl) begin
      for (int i = 0; i < N; i++) begin
        d = (i - m_ptr + N) % N;
        if (src_q[i].size() > 0 && d < bestd) begin
          best  = i;
          bestd = d;
        end
      end
    end
    exp_ready = '0;
    if (best >= 0) exp_ready[best] = 1'b1;
    chk("src_ready", 64'(src_ready_o), 64'(exp_ready));
    if (best >= 0) begin
      exp_q.push_back('{term: src_q[best][0], cyc: cyc});
      void'(src_q[best].pop_front());
      glog.push_back(best);
      m_ptr = (best + 1) % N;
      m_cnt++;
    end
  endtask

  // Monitor: every non-empty broadcast must be the next expected term, one cycle after grant
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (!reset_i) begin
        chk("bcast_cnt", 64'(bcast_cnt_o), 64'(m_cnt));
        if (cdb_term_o.tag != NO_VAL) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_bcast", 64'(cdb_term_o), 64'(mk(NO_VAL, cdb_term_o.val)));
          end else begin
            e = exp_q.pop_front();
            chk("cdb_term", 64'(cdb_term_o), 64'(e.term));
            chk("cdb_latency", 64'(cyc), 64'(e.cyc + 1));
          end
        end else if (exp_q.size() > 0 && exp_q[0].cyc + 1 <= cyc) begin
          e = exp_q.pop_front();
          chk("missing_bcast", 64'(cdb_term_o), 64'(e.term));
        end
      end
    end
  end

  initial begin
    int unsigned base;
    int pending;
    int n0;

    reset_i = 1'b1;
    flush_i = 1'b0;
    for (int i = 0; i < N; i++) src_term_i[i] = mk(NO_VAL, 32'h0);
    #12;
    chk("init_tag", 64'(cdb_term_o.tag), 64'(NO_VAL));
    chk("init_val", 64'(cdb_term_o.val), 64'h0);
    chk("init_cnt", 64'(bcast_cnt_o), 64'h0);
    chk("init_ready", 64'(src_ready_o), 64'h0);
    @(posedge clk_i); #2;
    reset_i = 1'b0;

    // Single source FU2
    src_q[2].push_back(mk(ALU_1, 32'hDEAD_BEEF));
    step(1'b0);
    step(1'b0);
    step(1'b0);
    chk("single_cnt", 64'(bcast_cnt_o), 64'd1);

    // Mid-run asynchronous reset with all four requesting
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 3; k++) src_q[i].push_back(rnd_term());
    step(1'b0);
    step(1'b0);
    step(1'b0);
    @(posedge clk_i); #2;
    reset_i = 1'b1;
    #1;
    chk("rst_tag", 64'(cdb_term_o.tag), 64'(NO_VAL));
    chk("rst_val", 64'(cdb_term_o.val), 64'h0);
    chk("rst_cnt", 64'(bcast_cnt_o), 64'h0);
    chk("rst_ready", 64'(src_ready_o), 64'h0);
    exp_q.delete();
    m_ptr = 0;
    m_cnt = 0;
    step(1'b0);
    for (int i = 0; i < N; i++) src_q[i].delete();
    step(1'b0);
    @(posedge clk_i); #2;
    reset_i = 1'b0;

    // All four continuously requesting for 8 cycles, pointer starts at 0
    glog.delete();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 2; k++) src_q[i].push_back(rnd_term());
    for (int k = 0; k < 8; k++) step(1'b0);
    step(1'b0);
    step(1'b0);
    chk("rr8_len", 64'(glog.size()), 64'd8);
    for (int k = 0; k < 8; k++)
      if (k < glog.size()) chk("rr8_order", 64'(glog[k]), 64'(k % 4));
    chk("rr8_cnt", 64'(bcast_cnt_o), 64'd8);

    // Pointer wrap: FU2 alone moves pointer to 3, then FU1 and FU3 compete
    src_q[2].push_back(rnd_term());
    step(1'b0);
    glog.delete();
    src_q[1].push_back(rnd_term());
    src_q[3].push_back(rnd_term());
    step(1'b0);
    step(1'b0);
    step(1'b0);
    chk("wrap_len", 64'(glog.size()), 64'd2);
    if (glog.size() == 2) begin
      chk("wrap_first", 64'(glog[0]), 64'd3);
      chk("wrap_second", 64'(glog[1]), 64'd1);
    end

    // Flush with three requesters: nothing granted, then they are served
    base = m_cnt;
    glog.delete();
    for (int i = 0; i < 3; i++) src_q[i].push_back(rnd_term());
    step(1'b1);
    step(1'b1);
    step(1'b0);
    chk("flush_cnt_held", 64'(bcast_cnt_o), 64'(base));
    step(1'b0);
    step(1'b0);
    step(1'b0);
    chk("flush_regrant_cnt", 64'(bcast_cnt_o), 64'(base + 3));
    chk("flush_regrant_len", 64'(glog.size()), 64'd3);
    if (glog.size() == 3) chk("flush_first", 64'(glog[0]), 64'd2);

    // Hold check: FU0 loses three times, then is accepted exactly once
    src_q[0].push_back(rnd_term());
    step(1'b0);
    glog.delete();
    base = m_cnt;
    for (int i = 0; i < N; i++) src_q[i].push_back(rnd_term());
    for (int k = 0; k < 4; k++) step(1'b0);
    step(1'b0);
    n0 = 0;
    foreach (glog[k]) if (glog[k] == 0) n0++;
    chk("hold_fu0_once", 64'(n0), 64'd1);
    if (glog.size() == 4) chk("hold_fu0_last", 64'(glog[3]), 64'd0);
    chk("hold_cnt", 64'(bcast_cnt_o), 64'(base + 4));

    // Randomized traffic with occasional flushes
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 99) < 30 && src_q[i].size() < 4) src_q[i].push_back(rnd_term());
      step($urandom_range(0, 99) < 10);
    end

    // Drain with a bounded cycle budget
    for (int k = 0; k < 200; k++) begin
      pending = 0;
      for (int i = 0; i < N; i++) pending += src_q[i].size();
      if (pending == 0) break;
      step(1'b0);
    end
    pending = 0;
    for (int i = 0; i < N; i++) pending += src_q[i].size();
    chk("drain_pending", 64'(pending), 64'd0);
    step(1'b0);
    step(1'b0);
    chk("final_exp_empty", 64'(exp_q.size()), 64'd0);
    chk("final_cnt", 64'(bcast_cnt_o), 64'(m_cnt));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
